keypad_number_entry: RTL

Downstream consumer of the keypad scanner's `key_value`/`key_valid` pulse stream. It assembles decimal digit keypresses into a multi-digit entry and supports backspace and clear. On ENTER it converts the BCD entry to binary with a sequential multiply-accumulate and presents the result with a one-cycle valid strobe. It sits between the keypad scanner and the application logic (display driver and comparator).

---
 rtl/keypad_number_entry.sv | 129 ++++++++++++
 1 files changed

// File: rtl/keypad_number_entry.sv
// Builds a decimal entry from keypad digit strobes and, on ENTER, converts it to
// binary with one multiply-by-ten-and-add step per digit, most significant first.
module keypad_number_entry #(
    parameter int NUM_DIGITS = 3,
    parameter int OUT_W      = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [3:0]                       key_value,
    input  logic                             key_valid,
    output logic [4*NUM_DIGITS-1:0]          digits_bcd,
    output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_count,
    output logic                             busy,
    output logic [OUT_W-1:0]                 number_out,
    output logic                             number_valid,
    output logic                             entry_err
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int BW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] MAX_CNT = CW'(NUM_DIGITS);

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    // state   | meaning
    // IDLE    | accepting digits / edit keys
    // CONVERT | one multiply-accumulate per cycle, MSD first
    // DONE    | publish result, clear entry
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] acc;
    logic [CW-1:0]    idx;
    logic [3:0]       cur_digit;
    logic [OUT_W-1:0] acc_next;
    logic             key_is_digit;

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == CW'(i)) begin
                cur_digit = digits_bcd[4*i +: 4];
            end
        end
    end

    assign acc_next     = (acc << 3) + (acc << 1) + OUT_W'(cur_digit);
    assign key_is_digit = (key_value <= 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            idx          <= '0;
            digits_bcd   <= '0;
            digit_count  <= '0;
            busy         <= 1'b0;
            number_out   <= '0;
            number_valid <= 1'b0;
            entry_err    <= 1'b0;
        end else begin
            number_valid <= 1'b0;
            entry_err    <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (key_valid) begin
                        if (key_is_digit) begin
                            if (digit_count < MAX_CNT) begin
                                digits_bcd  <= (digits_bcd << 4) | BW'(key_value);
                                digit_count <= digit_count + CW'(1);
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end else begin
                            case (key_value)
                                KEY_ENTER: begin
                                    if (digit_count == '0) begin
                                        entry_err <= 1'b1;
                                    end else begin
                                        acc   <= '0;
                                        idx   <= digit_count - CW'(1);
                                        busy  <= 1'b1;
                                        state <= CONVERT;
                                    end
                                end
                                KEY_BACK: begin
                                    if (digit_count != '0) begin
                                        digits_bcd  <= digits_bcd >> 4;
                                        digit_count <= digit_count - CW'(1);
                                    end
                                end
                                KEY_CLEAR: begin
                                    digits_bcd  <= '0;
                                    digit_count <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CONVERT: begin
                    acc <= acc_next;
                    if (idx == '0) begin
                        state <= DONE;
                    end else begin
                        idx <= idx - CW'(1);
                    end
                end
                DONE: begin
                    // busy stays high through the commit cycle; IDLE drops it
                    number_out   <= acc;
                    number_valid <= 1'b1;
                    digits_bcd   <= '0;
                    digit_count  <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
